// File: rtl/nwr_stream_gen.sv
// nwr_stream_gen: NWRITE traffic generator that feeds the db_req user stream.
// A start command produces num_pkts packets of len bytes each. The address
// advances by the beat-rounded length after every packet, and the data
// counter keeps running across commands until reset.
module nwr_stream_gen #(
   parameter logic [63:0] BASE_SEED = 64'h0,
   parameter int          MAX_BYTES = 256
) (
   input  logic        log_clk,
   input  logic        log_rst,
   input  logic        start_in,
   input  logic [8:0]  len_in,
   input  logic [7:0]  num_pkts_in,
   input  logic [33:0] addr_in,
   input  logic        nwr_ready_in,
   input  logic        nwr_busy_in,
   input  logic        user_tready_in,
   output logic [33:0] user_addr_o,
   output logic [3:0]  user_ftype_o,
   output logic [3:0]  user_ttype_o,
   output logic [11:0] user_tsize_o,
   output logic [63:0] user_tdata_o,
   output logic        user_tvalid_o,
   output logic [7:0]  user_tkeep_o,
   output logic        user_tlast_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o
);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] WAIT_RDY = 2'd1;
   localparam logic [1:0] SEND     = 2'd2;
   localparam logic [1:0] GAP      = 2'd3;

   localparam logic [9:0] MAX_LEN = 10'(MAX_BYTES);

   logic [1:0]  state;
   logic [8:0]  len_q;
   logic [7:0]  pkts_left;
   logic [33:0] addr_q;
   logic [6:0]  beat_idx;
   logic [63:0] data_cnt;
   logic        done_q;
   logic        err_q;

   logic [6:0]  nbeats;
   logic        last_beat;
   logic        cmd_legal;
   logic        beat_acc;

   // Beats per packet is ceil(len/8); the last beat is the one at index nbeats-1.
   assign nbeats    = 7'((len_q + 9'd7) >> 3);
   assign last_beat = (beat_idx == nbeats - 7'd1);
   assign cmd_legal = (len_in != 9'd0) && ({1'b0, len_in} <= MAX_LEN) && (num_pkts_in != 8'd0);
   assign beat_acc  = (state == SEND) && user_tready_in;

   // Command sequencing, per-packet beat tracking and the running data counter.
   always_ff @(posedge log_clk or posedge log_rst) begin
      if (log_rst) begin
         state     <= IDLE;
         len_q     <= '0;
         pkts_left <= '0;
         addr_q    <= '0;
         beat_idx  <= '0;
         data_cnt  <= BASE_SEED;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state)
            IDLE: begin
               if (start_in) begin
                  if (cmd_legal) begin
                     len_q     <= len_in;
                     pkts_left <= num_pkts_in;
                     addr_q    <= addr_in;
                     beat_idx  <= '0;
                     state     <= WAIT_RDY;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            WAIT_RDY: begin
               if (nwr_ready_in && !nwr_busy_in) state <= SEND;
            end
            SEND: begin
               if (beat_acc) begin
                  data_cnt <= data_cnt + 64'd1;
                  if (last_beat) begin
                     beat_idx <= '0;
                     state    <= GAP;
                  end else begin
                     beat_idx <= beat_idx + 7'd1;
                  end
               end
            end
            default: begin
               // GAP: step to the next packet; address wraps naturally at 34 bits.
               pkts_left <= pkts_left - 8'd1;
               addr_q    <= addr_q + {24'd0, nbeats, 3'b000};
               if (pkts_left == 8'd1) begin
                  done_q <= 1'b1;
                  state  <= IDLE;
               end else begin
                  state <= WAIT_RDY;
               end
            end
         endcase
      end
   end

   // Stream outputs are decoded from registered state so they hold while stalled.
   always_comb begin
      user_tvalid_o = (state == SEND);
      user_tdata_o  = (state == SEND) ? data_cnt : 64'd0;
      user_tlast_o  = (state == SEND) && last_beat;
      user_tkeep_o  = 8'h00;
      if (state == SEND) begin
         if (last_beat && (len_q[2:0] != 3'd0)) user_tkeep_o = ~(8'hFF >> len_q[2:0]);
         else                                   user_tkeep_o = 8'hFF;
      end
   end

   assign user_addr_o  = addr_q;
   assign user_tsize_o = {3'b000, len_q};
   assign user_ftype_o = 4'h5;
   assign user_ttype_o = 4'h4;
   assign busy_o       = (state != IDLE);
   assign done_o       = done_q;
   assign err_o        = err_q;

endmodule
